cnn16_mem_arbiter: RTL

CNN16_MEM_ARBITER -- requirements
Module: cnn16_mem_arbiter

---
 rtl/cnn16_mem_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cnn16_mem_arbiter.sv
// Two-port (CPU core / conv engine) arbiter onto a single request/ready memory port.
// Round-robin by default; define CNN16_ARB_FIXED_PRIO_EN for fixed priority to port 0.
module cnn16_mem_arbiter #(
   parameter int unsigned AW      = 12,
   parameter int unsigned DW      = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          err,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic [1:0]    arb_state
);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StBusy = 2'b01,
      StResp = 2'b10
   } state_e;

   localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

   state_e     state_q;
   logic       winner_q;
   logic [7:0] cnt_q;
   logic       grant;
   logic       busy_done;
   logic       timed_out;

   // cnt_q holds the number of BUSY cycles already finished, so CntLast marks the last one
   assign busy_done = mem_ready || (cnt_q == CntLast);
   assign timed_out = !mem_ready && (cnt_q == CntLast);
   assign arb_state = state_q;

`ifdef CNN16_ARB_FIXED_PRIO_EN
   assign grant = ~req0;
`else
   logic last_q;

   always_comb begin
      grant = req1;
      if (req0 && req1) begin
         grant = ~last_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q <= 1'b1;
      end else if (state_q == StBusy && busy_done) begin
         last_q <= winner_q;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         winner_q  <= 1'b0;
         cnt_q     <= 8'd0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
         err       <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req0 || req1) begin
                  winner_q  <= grant;
                  mem_req   <= 1'b1;
                  mem_we    <= grant ? we1 : we0;
                  mem_addr  <= grant ? addr1 : addr0;
                  mem_wdata <= grant ? wdata1 : wdata0;
                  cnt_q     <= 8'd0;
                  state_q   <= StBusy;
               end
            end
            StBusy: begin
               cnt_q <= cnt_q + 8'd1;
               if (busy_done) begin
                  if (timed_out) begin
                     err <= 1'b1;
                     if (winner_q) rdata1 <= '0;
                     else          rdata0 <= '0;
                  end else if (!mem_we) begin
                     if (winner_q) rdata1 <= mem_rdata;
                     else          rdata0 <= mem_rdata;
                  end
                  mem_req <= 1'b0;
                  ack0    <= ~winner_q;
                  ack1    <= winner_q;
                  state_q <= StResp;
               end
            end
            StResp: begin
               ack0    <= 1'b0;
               ack1    <= 1'b0;
               err     <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               mem_req <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
